// File: rtl/pixel_scheduler.sv
// pixel_scheduler: in-order raster pixel dispatch to N depth engines with ordered retire; SCHED_PERF_CNT_EN adds frame_cycles
module pixel_scheduler #(
  parameter int N_ENGINES = 4,
  parameter int X_SIZE = 640,
  parameter int Y_SIZE = 480
) (
  input  logic                   out_stream_aclk,
  input  logic                   periph_resetn,
  input  logic                   enable,
  input  logic [7:0]             cfg_max_iter,
  output logic [N_ENGINES-1:0]   eng_start,
  output logic [9:0]             eng_x,
  output logic [8:0]             eng_y,
  output logic [7:0]             eng_max_iter,
  input  logic [N_ENGINES-1:0]   eng_done,
  input  logic [8*N_ENGINES-1:0] eng_depth,
  output logic [7:0]             out_depth,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_sof,
  output logic                   out_eol,
  output logic                   frame_done
`ifdef SCHED_PERF_CNT_EN
  ,
  output logic [31:0]            frame_cycles
`endif
);
  localparam int PW = N_ENGINES > 1 ? $clog2(N_ENGINES) : 1;
  typedef enum logic [1:0] {IDLE, BUSY, HELD} eng_state_t;
  eng_state_t st [N_ENGINES];
  logic [7:0] hold [N_ENGINES];
  logic [PW-1:0] ip, rp;
  logic [9:0] ix, ox;
  logic [8:0] iy, oy;
  logic [7:0] frame_limit;
  logic at_origin, issue, retire, last_out;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return p == PW'(N_ENGINES - 1) ? '0 : p + 1'b1;
  endfunction
  assign at_origin = ix == '0 && iy == '0;
  // A disabled gate only blocks the start of a new frame, never its middle.
  assign issue = (enable || !at_origin) && st[ip] == IDLE;
  assign out_valid = st[rp] == HELD;
  assign retire = out_valid && out_ready;
  assign out_depth = out_valid ? hold[rp] : '0;
  assign out_sof = out_valid && ox == '0 && oy == '0;
  assign out_eol = out_valid && ox == 10'(X_SIZE - 1);
  assign last_out = ox == 10'(X_SIZE - 1) && oy == 9'(Y_SIZE - 1);
  always_ff @(posedge out_stream_aclk or negedge periph_resetn)
    if (!periph_resetn) begin
      for (int i = 0; i < N_ENGINES; i++) begin
        st[i] <= IDLE;
        hold[i] <= '0;
      end
      ip <= '0;
      rp <= '0;
      ix <= '0;
      iy <= '0;
      ox <= '0;
      oy <= '0;
      frame_limit <= '0;
      eng_start <= '0;
      eng_x <= '0;
      eng_y <= '0;
      eng_max_iter <= '0;
      frame_done <= 1'b0;
    end else begin
      eng_start <= '0;
      frame_done <= retire && last_out;
      // Issue needs IDLE, capture needs BUSY, retire needs HELD: no engine sees two updates.
      for (int i = 0; i < N_ENGINES; i++)
        if (eng_done[i] && st[i] == BUSY) begin
          st[i] <= HELD;
          hold[i] <= eng_depth[8*i +: 8];
        end
      if (retire) begin
        st[rp] <= IDLE;
        rp <= nxt(rp);
        ox <= ox == 10'(X_SIZE - 1) ? '0 : ox + 1'b1;
        oy <= ox == 10'(X_SIZE - 1) ? (oy == 9'(Y_SIZE - 1) ? '0 : oy + 1'b1) : oy;
      end
      if (issue) begin
        eng_start[ip] <= 1'b1;
        st[ip] <= BUSY;
        ip <= nxt(ip);
        eng_x <= ix;
        eng_y <= iy;
        eng_max_iter <= at_origin ? cfg_max_iter : frame_limit;
        if (at_origin) frame_limit <= cfg_max_iter;
        ix <= ix == 10'(X_SIZE - 1) ? '0 : ix + 1'b1;
        iy <= ix == 10'(X_SIZE - 1) ? (iy == 9'(Y_SIZE - 1) ? '0 : iy + 1'b1) : iy;
      end
    end
`ifdef SCHED_PERF_CNT_EN
  // Two slots because the next frame's first issue can precede this frame's last retire.
  logic fi, fr;
  logic [1:0] run;
  logic [31:0] cnt [2];
  always_ff @(posedge out_stream_aclk or negedge periph_resetn)
    if (!periph_resetn) begin
      fi <= 1'b0;
      fr <= 1'b0;
      run <= '0;
      cnt[0] <= '0;
      cnt[1] <= '0;
      frame_cycles <= '0;
    end else begin
      for (int k = 0; k < 2; k++)
        if (issue && at_origin && fi == 1'(k)) begin
          cnt[k] <= 32'd1;
          run[k] <= 1'b1;
        end else if (run[k] && cnt[k] != '1)
          cnt[k] <= cnt[k] + 1'b1;
      if (issue && at_origin) fi <= ~fi;
      if (retire && last_out) begin
        frame_cycles <= cnt[fr] == '1 ? cnt[fr] : cnt[fr] + 1'b1;
        run[fr] <= 1'b0;
        fr <= ~fr;
      end
    end
`endif
endmodule

// File: tb/tb_pixel_scheduler.sv
// tb_pixel_scheduler: directed bench with engine responder and raster-order retire monitor
module tb_pixel_scheduler;
  localparam int NE = 4, XS = 8, YS = 3;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic periph_resetn, enable, out_ready, auto_en, mon_en;
  logic [7:0] cfg_max_iter, eng_max_iter, out_depth;
  logic [NE-1:0] eng_start, eng_done, auto_done, man_done;
  logic [9:0] eng_x;
  logic [8:0] eng_y;
  logic [8*NE-1:0] eng_depth, auto_dep, man_dep;
  logic out_valid, out_sof, out_eol, frame_done;
  int n_cmp = 0, n_bad = 0, n_fd = 0, n_ret = 0, n_eol = 0, n_starts = 0, fcnt = 0, snap;
  assign eng_done = auto_done | man_done;
  assign eng_depth = auto_en ? auto_dep : man_dep;
`ifdef SCHED_PERF_CNT_EN
  logic [31:0] fc_main, p_fc;
  logic [0:0] p_start, p_done;
  logic [9:0] p_x;
  logic [8:0] p_y;
  logic [7:0] p_mi, p_dep, p_depth;
  logic p_valid, p_sof, p_eol, p_fd, perf_ok = 1'b0;
`endif
  pixel_scheduler #(.N_ENGINES(NE), .X_SIZE(XS), .Y_SIZE(YS)) dut (
    .out_stream_aclk(clk), .periph_resetn(periph_resetn), .enable(enable),
    .cfg_max_iter(cfg_max_iter), .eng_start(eng_start), .eng_x(eng_x), .eng_y(eng_y),
    .eng_max_iter(eng_max_iter), .eng_done(eng_done), .eng_depth(eng_depth),
    .out_depth(out_depth), .out_valid(out_valid), .out_ready(out_ready),
    .out_sof(out_sof), .out_eol(out_eol), .frame_done(frame_done)
`ifdef SCHED_PERF_CNT_EN
    , .frame_cycles(fc_main)
`endif
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  function automatic logic [7:0] pix_depth(input int x, input int y);
    return 8'(x * 7 + y * 16 + 3);
  endfunction
  // engine responder: fixed 3-cycle latency, depth derived from the pixel coordinates
  initial begin
    int tmr [NE];
    logic [7:0] dep [NE];
    auto_done = '0;
    auto_dep = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < NE; i++) begin
        auto_done[i] = 1'b0;
        if (!periph_resetn || !auto_en) tmr[i] = 0;
        else begin
          if (tmr[i] > 0) begin
            tmr[i]--;
            if (tmr[i] == 0) begin
              auto_done[i] = 1'b1;
              auto_dep[8*i +: 8] = dep[i];
            end
          end
          if (eng_start[i]) begin
            tmr[i] = 3;
            dep[i] = pix_depth(int'(eng_x), int'(eng_y));
          end
        end
      end
    end
  end
  // monitor: raster-order retire model, frame limit per frame, frame_done placement
  initial begin
    int mx, my;
    logic prev_end, hs;
    mx = 0; my = 0; prev_end = 1'b0;
    forever begin
      @(negedge clk);
      if (!periph_resetn) begin
        mx = 0; my = 0; prev_end = 1'b0;
      end else if (mon_en) begin
        if (eng_start != '0) begin
          n_starts++;
          check("start_onehot", 32'($onehot(eng_start)), 1);
          if (eng_x == '0 && eng_y == '0) fcnt++;
          check("max_iter", eng_max_iter, fcnt <= 1 ? 200 : 50);
        end
        if (frame_done || prev_end) check("frame_done_pos", frame_done, prev_end);
        if (frame_done) n_fd++;
        hs = out_valid && out_ready;
        if (hs) begin
          check("ret_depth", out_depth, pix_depth(mx, my));
          check("ret_sof", out_sof, mx == 0 && my == 0);
          check("ret_eol", out_eol, mx == XS - 1);
          n_ret++;
          if (out_eol) n_eol++;
        end
        prev_end = hs && mx == XS - 1 && my == YS - 1;
        if (hs) begin
          my = mx == XS - 1 ? (my == YS - 1 ? 0 : my + 1) : my;
          mx = mx == XS - 1 ? 0 : mx + 1;
        end
      end
    end
  end
`ifdef SCHED_PERF_CNT_EN
  pixel_scheduler #(.N_ENGINES(1), .X_SIZE(4), .Y_SIZE(2)) perf (
    .out_stream_aclk(clk), .periph_resetn(periph_resetn), .enable(1'b1),
    .cfg_max_iter(8'd9), .eng_start(p_start), .eng_x(p_x), .eng_y(p_y),
    .eng_max_iter(p_mi), .eng_done(p_done), .eng_depth(p_dep),
    .out_depth(p_depth), .out_valid(p_valid), .out_ready(1'b1),
    .out_sof(p_sof), .out_eol(p_eol), .frame_done(p_fd), .frame_cycles(p_fc)
  );
  initial begin
    int cyc, s, r, nr;
    cyc = 0; s = -1; r = -1; nr = 0;
    p_done = '0; p_dep = '0;
    @(posedge periph_resetn);
    while (!perf_ok && cyc < 200) begin
      @(negedge clk);
      cyc++;
      p_done = p_start;
      p_dep = 8'(p_x + 1);
      if (p_start[0] && p_x == '0 && p_y == '0 && s < 0) s = cyc;
      if (p_valid && nr < 8) begin
        nr++;
        if (nr == 8) r = cyc;
      end
      if (p_fd) begin
        check("perf_frame_cycles", p_fc, 32'(r - s + 2));
        check("perf_nonzero", 32'(p_fc != '0), 1);
        perf_ok = 1'b1;
      end
    end
  end
`endif
  initial begin
    periph_resetn = 1'b0; enable = 1'b0; out_ready = 1'b1; cfg_max_iter = 8'd200;
    auto_en = 1'b1; mon_en = 1'b1; man_done = '0; man_dep = '0;
    repeat (2) @(negedge clk);
    check("rst_start", eng_start, 0);
    check("rst_valid", out_valid, 0);
    check("rst_depth", out_depth, 0);
    check("rst_sof", out_sof, 0);
    check("rst_eol", out_eol, 0);
    check("rst_frame_done", frame_done, 0);
    enable = 1'b1;
    periph_resetn = 1'b1;
    for (int i = 0; i < 20 && eng_start == '0; i++) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      check("first_start", eng_start, 1 << k);
      check("first_x", eng_x, k);
      check("first_y", eng_y, 0);
      @(negedge clk);
    end
    cfg_max_iter = 8'd50;
    for (int i = 0; i < 500 && n_fd < 1; i++) @(negedge clk);
    check("frame0_done", n_fd, 1);
    repeat (3) @(negedge clk);
    enable = 1'b0;
    for (int i = 0; i < 500 && n_fd < 2; i++) @(negedge clk);
    check("frame1_done", n_fd, 2);
    snap = n_starts;
    repeat (20) @(negedge clk);
    check("no_issue_disabled", n_starts - snap, 0);
    check("frames_started", fcnt, 2);
    check("retire_count", n_ret, 2 * XS * YS);
    check("eol_count", n_eol, 2 * YS);
    check("frame_done_total", n_fd, 2);
    check("idle_valid", out_valid, 0);
    mon_en = 1'b0; auto_en = 1'b0;
    @(negedge clk);
    periph_resetn = 1'b0; enable = 1'b1; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    periph_resetn = 1'b1;
    repeat (6) @(negedge clk);
    check("busy_no_valid", out_valid, 0);
    man_dep[15:8] = 8'h22; man_done = 4'b0010;
    @(negedge clk);
    man_dep[7:0] = 8'h11; man_done = 4'b0001;
    check("ooo_held_back", out_valid, 0);
    @(negedge clk);
    man_dep[23:16] = 8'h33; man_dep[31:24] = 8'h44; man_done = 4'b1100;
    check("head_valid", out_valid, 1);
    check("head_depth", out_depth, 8'h11);
    check("head_sof", out_sof, 1);
    @(negedge clk);
    man_done = '0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("stall_start", eng_start, 0);
      check("stall_valid", out_valid, 1);
      check("stall_depth", out_depth, 8'h11);
      check("stall_sof", out_sof, 1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("drain1_depth", out_depth, 8'h22);
    check("drain1_sof", out_sof, 0);
    check("no_same_cycle_reissue", eng_start, 0);
    @(negedge clk);
    check("drain2_depth", out_depth, 8'h33);
    check("reissue_start", eng_start, 1);
    check("reissue_x", eng_x, 4);
    @(negedge clk);
    check("drain3_valid", out_valid, 1);
    check("drain3_depth", out_depth, 8'h44);
    @(negedge clk);
    check("drained_valid", out_valid, 0);
    @(negedge clk);
    periph_resetn = 1'b0; enable = 1'b0;
    #1;
    check("async_rst_start", eng_start, 0);
    check("async_rst_valid", out_valid, 0);
    check("async_rst_depth", out_depth, 0);
    @(negedge clk);
    periph_resetn = 1'b1;
    @(negedge clk);
    man_dep[23:16] = 8'h55; man_done = 4'b0100;
    @(negedge clk);
    man_done = '0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("stale_done_valid", out_valid, 0);
    end
    enable = 1'b1;
    for (int i = 0; i < 10 && eng_start == '0; i++) @(negedge clk);
    check("restart_start", eng_start, 1);
    check("restart_x", eng_x, 0);
    check("restart_y", eng_y, 0);
`ifdef SCHED_PERF_CNT_EN
    check("perf_seen", 32'(perf_ok), 1);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
